// File: rtl/std_cache_axi_wr_scheduler.sv
// Shares one AXI write path (AW + W) between several cache requesters.
// Round-robin AW grant; W beats steered in AW order via a ticket queue.
module std_cache_axi_wr_scheduler #(
  parameter int unsigned NumPorts       = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AwWidth        = 64,
  parameter int unsigned WWidth         = 73
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumPorts-1:0]                  aw_valid_i,
  input  logic [NumPorts*AwWidth-1:0]          aw_data_i,
  output logic [NumPorts-1:0]                  aw_ready_o,
  input  logic [NumPorts-1:0]                  w_valid_i,
  input  logic [NumPorts*WWidth-1:0]           w_data_i,
  input  logic [NumPorts-1:0]                  w_last_i,
  output logic [NumPorts-1:0]                  w_ready_o,
  output logic                                 aw_valid_o,
  output logic [AwWidth-1:0]                   aw_data_o,
  input  logic                                 aw_ready_i,
  output logic                                 w_valid_o,
  output logic [WWidth-1:0]                    w_data_o,
  output logic                                 w_last_o,
  input  logic                                 w_ready_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic                                 busy_o
);

  localparam int unsigned IdxW = $clog2(NumPorts);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = $clog2(MaxOutstanding+1);

  logic [NumPorts-1:0][AwWidth-1:0] aw_arr;
  logic [NumPorts-1:0][WWidth-1:0]  w_arr;
  assign aw_arr = aw_data_i;
  assign w_arr  = w_data_i;

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] locked_idx_q, locked_idx_d;
  logic [IdxW-1:0] mem_q [MaxOutstanding];
  logic [IdxW-1:0] mem_d [MaxOutstanding];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] gnt_rr, g, h;
  logic            found, full, empty;
  logic            aw_hs, push, pop;
  int unsigned     k;
  logic [IdxW-1:0] kk;

  // First requester at or after rr_ptr, wrapping around
  always_comb begin
    gnt_rr = rr_ptr_q;
    found  = 1'b0;
    k      = 0;
    kk     = '0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      k = int'(rr_ptr_q) + i;
      if (k >= NumPorts) k = k - NumPorts;
      kk = IdxW'(k);
      if (!found && aw_valid_i[kk]) begin
        found  = 1'b1;
        gnt_rr = kk;
      end
    end
  end

  assign g     = lock_q ? locked_idx_q : gnt_rr;
  assign full  = (cnt_q == CntW'(MaxOutstanding));
  assign empty = (cnt_q == '0);
  assign h     = mem_q[rd_ptr_q];

  assign aw_valid_o = aw_valid_i[g] && !full;
  assign aw_data_o  = aw_arr[g];
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign push       = aw_hs;

  always_comb begin
    aw_ready_o    = '0;
    aw_ready_o[g] = aw_ready_i && !full;
  end

  assign w_valid_o = !empty && w_valid_i[h];
  assign w_data_o  = w_arr[h];
  assign w_last_o  = w_last_i[h];
  assign pop       = w_valid_o && w_ready_i && w_last_o;

  always_comb begin
    w_ready_o    = '0;
    w_ready_o[h] = !empty && w_ready_i;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    if (aw_hs) begin
      lock_d   = 1'b0;
      rr_ptr_d = (g == IdxW'(NumPorts-1)) ? '0 : g + 1'b1;
    end else if (aw_valid_o) begin
      lock_d       = 1'b1;
      locked_idx_d = g;
    end
    if (push) begin
      mem_d[wr_ptr_q] = g;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Ticket storage needs no reset: pointers and count gate every read
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign outstanding_o = cnt_q;
  assign busy_o        = !empty || aw_valid_o;

endmodule
